unix_to_calendar_bcd: RTL and testbench
=======================================

// Module: unix_to_calendar_bcd
// PURPOSE
//  - Sits directly downstream of unixCounter. Converts its free-running seconds count (epoch 1970-01-01 00:00:00, UTC, no leap seconds)
//    into BCD year/month/day/hour/minute/second plus weekday. These feed the display path and the alarm/timer compare logic.
//  - Multi-cycle iterative converter. Re-converts automatically whenever the counter changes.
//  - Publishes all fields atomically on completion.
// PARAMETERS
//  N         64   width of counter input (matches unixCounter N)
//  MAX_YEAR  2099 last representable year; the /4 leap rule is exact over 1970..2099
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   asynchronous active-low reset
//  counter      in   N   seconds since epoch, from unixCounter
//  busy         out  1   conversion in progress
//  valid        out  1   1-cycle pulse: output fields updated this cycle
//  range_err    out  1   last converted value >= 4102444800 (year 2100 or later)
//  year_bcd     out  16  4-digit BCD year
//  month_bcd    out  8   01..12
//  day_bcd      out  8   01..31
//  hour_bcd     out  8   00..23
//  minute_bcd   out  8   00..59
//  second_bcd   out  8   00..59
//  weekday      out  3   0=Sun .. 6=Sat
// BEHAVIOUR
//  - Reset (async, all regs)
//    - Outputs = 1970-01-01 00:00:00; weekday=4; busy=valid=range_err=0.
//    - last_cnt=0.
//  - FSM states: IDLE -> DIV -> HMS -> YEAR -> MONTH -> DONE -> IDLE.
//  - IDLE
//    - If counter != last_cnt: latch counter into work reg and last_cnt; busy=1.
//    - If latched value >= 4102444800: go straight to DONE with clamp (see below); otherwise go to DIV.
//  - DIV: restoring divide by 86400, 1 quotient bit/cycle, N cycles.
//    - Produces days (quotient) and sod (remainder, 17b).
//  - HMS: repeated subtraction.
//    - Subtract 3600 from sod until < 3600, giving hour (<= 23 steps).
//    - Then subtract 60 until < 60, giving minute (<= 59 steps); the remainder is second.
//  - YEAR: year=1970, wd=4.
//    - While days >= ylen (366 if year%4==0, else 365): days -= ylen; year++; wd = (wd + ylen%7) mod 7.
//    - One year per cycle.
//  - MONTH: month=1.
//    - While days >= mlen(month,leap): days -= mlen; wd = (wd + mlen%7) mod 7; month++. Feb = 29 in leap years.
//    - Day = days+1. Weekday = (wd + days) mod 7.
//  - DONE
//    - Register all BCD fields, weekday and range_err in the same cycle; valid=1 for exactly 1 cycle; busy drops next cycle.
//  - Clamp for range_err=1: 2099-12-31 23:59:59, weekday=4.
//  - Latency from counter change to valid: <= N + 240 cycles (< 1 unixCounter tick at M=26).
//  - counter changes while busy: ignored mid-flight. On return to IDLE, counter != last_cnt triggers a new conversion on the next cycle.
//    The final outputs always match the latest counter.
//  - Output fields hold their values between valid pulses and never show partial results.
//  - rst_n low mid-conversion: immediate return to reset values; no valid pulse.
//  - Width rules
//    - days: 17b.
//    - year binary: 12b.
//    - wd arithmetic: mod 7, kept 3b.
//    - Never underflow: every subtract is guarded by a >= compare in the same cycle.
// STRUCTURE
//  - Shared package clock_pkg:
//    - Constants: SECS_PER_DAY=86400, EPOCH_YEAR=1970, EPOCH_WEEKDAY=4, MAX_UNIX=4102444799.
//    - FSM state encoding.
//    - Month-length function mlen(month,leap).
//  - One sub-module: bin_to_bcd.
//    - Combinational, 7-bit 0..99 in, 8-bit BCD out.
//    - Instantiated for month, day, hour, minute, second, and for the year split into century (19/20) and year-of-century.
// TESTING
//  1. Reset: all outputs 1970-01-01 00:00:00, wd=4, busy=0, no valid while counter stays 0.
//  2. counter=86399 -> valid within N+240 cycles: 1970-01-01 23:59:59, wd=4, range_err=0.
//  3. counter=951782400 -> 2000-02-29 00:00:00, wd=2 (leap Feb).
//     Then counter=951868800 -> 2000-03-01 00:00:00, wd=3.
//  4. counter=1700000000 -> 2023-11-14 22:13:20, wd=2.
//  5. counter=4102444799 -> 2099-12-31 23:59:59, range_err=0.
//     Then counter=4102444800 -> same fields, wd=4, range_err=1.
//  6. Change counter 1700000000 -> 0 while busy: first valid shows 2023-11-14 22:13:20, second valid shows 1970-01-01 00:00:00.
//     Separately, assert rst_n mid-busy: outputs reset immediately, no valid.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared constants, FSM encoding and calendar helpers for the seconds-to-calendar converter.
package clock_pkg;

  localparam logic [16:0] SECS_PER_DAY  = 17'd86400;
  localparam logic [11:0] EPOCH_YEAR    = 12'd1970;
  localparam logic [2:0]  EPOCH_WEEKDAY = 3'd4;
  localparam logic [63:0] MAX_UNIX      = 64'd4102444799;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DIV   = 3'd1;
  localparam logic [2:0] S_HMS   = 3'd2;
  localparam logic [2:0] S_YEAR  = 3'd3;
  localparam logic [2:0] S_MONTH = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  function automatic logic [4:0] mlen(input logic [3:0] month, input logic leap);
    case (month)
      4'd2:                       mlen = leap ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:    mlen = 5'd30;
      default:                    mlen = 5'd31;
    endcase
  endfunction

  // Advance a weekday by len days, result kept in 0..6.
  function automatic logic [2:0] wd_add(input logic [2:0] wd, input logic [4:0] len);
    logic [3:0] s;
    s = {1'b0, wd} + 4'(len % 5'd7);
    wd_add = (s >= 4'd7) ? 3'(s - 4'd7) : s[2:0];
  endfunction

endpackage

// File: rtl/bin_to_bcd.sv
// Combinational 0..99 binary to two-digit BCD.
module bin_to_bcd (
  input  logic [6:0] i_bin,
  output logic [7:0] o_bcd
);

  logic [6:0] w_tens;
  logic [6:0] w_ones;

  assign w_tens = i_bin / 7'd10;
  assign w_ones = i_bin % 7'd10;
  assign o_bcd  = {4'(w_tens), 4'(w_ones)};

endmodule

// File: rtl/unix_to_calendar_bcd.sv
// Iterative Unix-seconds to BCD calendar converter; re-runs whenever counter changes.
// Latency <= N+240 cycles; counter changes while busy are picked up after the current result.
module unix_to_calendar_bcd
  import clock_pkg::*;
#(
  parameter int N        = 64,
  parameter int MAX_YEAR = 2099
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] counter,
  output logic         busy,
  output logic         valid,
  output logic         range_err,
  output logic [15:0]  year_bcd,
  output logic [7:0]   month_bcd,
  output logic [7:0]   day_bcd,
  output logic [7:0]   hour_bcd,
  output logic [7:0]   minute_bcd,
  output logic [7:0]   second_bcd,
  output logic [2:0]   weekday
);

  localparam int           BW    = $clog2(N);
  localparam logic [N-1:0] LIMIT = N'(MAX_UNIX);

  logic [2:0]    r_state;
  logic [N-1:0]  r_last;
  logic [N-1:0]  r_work;
  logic [16:0]   r_rem;
  logic [BW-1:0] r_bitcnt;
  logic [16:0]   r_days;
  logic [4:0]    r_hour;
  logic [5:0]    r_min;
  logic [11:0]   r_year;
  logic [3:0]    r_month;
  logic [2:0]    r_wd;
  logic          r_clamp;

  logic          r_busy;
  logic          r_valid;
  logic          r_range;
  logic [15:0]   r_year_bcd;
  logic [7:0]    r_month_bcd;
  logic [7:0]    r_day_bcd;
  logic [7:0]    r_hour_bcd;
  logic [7:0]    r_minute_bcd;
  logic [7:0]    r_second_bcd;
  logic [2:0]    r_weekday;

  logic [17:0]   w_rem_sh;
  logic          w_qbit;
  logic          w_leap;
  logic [8:0]    w_ylen;
  logic [4:0]    w_mlen;
  logic [4:0]    w_day;
  logic [2:0]    w_wd_final;
  logic [6:0]    w_cent;
  logic [6:0]    w_yoc;
  logic [7:0]    w_cent_bcd, w_yoc_bcd, w_month_bcd, w_day_bcd;
  logic [7:0]    w_hour_bcd, w_minute_bcd, w_second_bcd;

  assign w_rem_sh   = {r_rem, r_work[N-1]};
  assign w_qbit     = (w_rem_sh >= {1'b0, SECS_PER_DAY});
  assign w_leap     = (r_year[1:0] == 2'b00);
  assign w_ylen     = w_leap ? 9'd366 : 9'd365;
  assign w_mlen     = mlen(r_month, w_leap);
  assign w_day      = 5'(r_days[4:0] + 5'd1);
  assign w_wd_final = r_clamp ? EPOCH_WEEKDAY : 3'((6'(r_wd) + 6'(r_days[4:0])) % 6'd7);
  assign w_cent     = (r_year >= 12'd2000) ? 7'd20 : 7'd19;
  assign w_yoc      = 7'(r_year - 12'(w_cent) * 12'd100);

  bin_to_bcd u_cent   (.i_bin(w_cent),         .o_bcd(w_cent_bcd));
  bin_to_bcd u_yoc    (.i_bin(w_yoc),          .o_bcd(w_yoc_bcd));
  bin_to_bcd u_month  (.i_bin(7'(r_month)),    .o_bcd(w_month_bcd));
  bin_to_bcd u_day    (.i_bin(7'(w_day)),      .o_bcd(w_day_bcd));
  bin_to_bcd u_hour   (.i_bin(7'(r_hour)),     .o_bcd(w_hour_bcd));
  bin_to_bcd u_minute (.i_bin(7'(r_min)),      .o_bcd(w_minute_bcd));
  bin_to_bcd u_second (.i_bin(7'(r_rem[5:0])), .o_bcd(w_second_bcd));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last       <= '0;
      r_work       <= '0;
      r_rem        <= '0;
      r_bitcnt     <= '0;
      r_days       <= '0;
      r_hour       <= '0;
      r_min        <= '0;
      r_year       <= EPOCH_YEAR;
      r_month      <= 4'd1;
      r_wd         <= EPOCH_WEEKDAY;
      r_clamp      <= 1'b0;
      r_busy       <= 1'b0;
      r_valid      <= 1'b0;
      r_range      <= 1'b0;
      r_year_bcd   <= 16'h1970;
      r_month_bcd  <= 8'h01;
      r_day_bcd    <= 8'h01;
      r_hour_bcd   <= 8'h00;
      r_minute_bcd <= 8'h00;
      r_second_bcd <= 8'h00;
      r_weekday    <= EPOCH_WEEKDAY;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_busy <= (counter != r_last);
          if (counter != r_last) begin
            r_last   <= counter;
            r_work   <= counter;
            r_rem    <= '0;
            r_bitcnt <= BW'(N - 1);
            r_hour   <= '0;
            r_min    <= '0;
            // Out-of-range values skip the datapath and publish the last representable second.
            if (counter > LIMIT) begin
              r_clamp <= 1'b1;
              r_year  <= 12'(MAX_YEAR);
              r_month <= 4'd12;
              r_days  <= 17'd30;
              r_hour  <= 5'd23;
              r_min   <= 6'd59;
              r_rem   <= 17'd59;
              r_state <= S_DONE;
            end else begin
              r_clamp <= 1'b0;
              r_state <= S_DIV;
            end
          end
        end
        S_DIV: begin
          r_rem  <= w_qbit ? 17'(w_rem_sh - {1'b0, SECS_PER_DAY}) : w_rem_sh[16:0];
          r_work <= {r_work[N-2:0], w_qbit};
          if (r_bitcnt == '0) r_state  <= S_HMS;
          else                r_bitcnt <= r_bitcnt - 1'b1;
        end
        S_HMS: begin
          if (r_rem >= 17'd3600) begin
            r_rem  <= r_rem - 17'd3600;
            r_hour <= r_hour + 5'd1;
          end else if (r_rem >= 17'd60) begin
            r_rem <= r_rem - 17'd60;
            r_min <= r_min + 6'd1;
          end else begin
            r_days  <= r_work[16:0];
            r_year  <= EPOCH_YEAR;
            r_wd    <= EPOCH_WEEKDAY;
            r_state <= S_YEAR;
          end
        end
        S_YEAR: begin
          if (r_days >= 17'(w_ylen)) begin
            r_days <= r_days - 17'(w_ylen);
            r_year <= r_year + 12'd1;
            r_wd   <= wd_add(r_wd, w_leap ? 5'd2 : 5'd1);
          end else begin
            r_month <= 4'd1;
            r_state <= S_MONTH;
          end
        end
        S_MONTH: begin
          if (r_days >= 17'(w_mlen)) begin
            r_days  <= r_days - 17'(w_mlen);
            r_wd    <= wd_add(r_wd, w_mlen);
            r_month <= r_month + 4'd1;
          end else begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_year_bcd   <= {w_cent_bcd, w_yoc_bcd};
          r_month_bcd  <= w_month_bcd;
          r_day_bcd    <= w_day_bcd;
          r_hour_bcd   <= w_hour_bcd;
          r_minute_bcd <= w_minute_bcd;
          r_second_bcd <= w_second_bcd;
          r_weekday    <= w_wd_final;
          r_range      <= r_clamp;
          r_valid      <= 1'b1;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign valid      = r_valid;
  assign range_err  = r_range;
  assign year_bcd   = r_year_bcd;
  assign month_bcd  = r_month_bcd;
  assign day_bcd    = r_day_bcd;
  assign hour_bcd   = r_hour_bcd;
  assign minute_bcd = r_minute_bcd;
  assign second_bcd = r_second_bcd;
  assign weekday    = r_weekday;

endmodule

// File: tb/tb_unix_to_calendar_bcd.sv
// Directed bench for unix_to_calendar_bcd: calendar reference model, per-cycle output compare,
// and literal expectations for the documented dates.
module tb_unix_to_calendar_bcd;

  localparam int N       = 64;
  localparam int LAT_MAX = N + 240;

  typedef struct packed {
    logic [55:0] f;
    logic [2:0]  wd;
    logic        re;
  } cal_t;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  counter;
  logic          busy, valid, range_err;
  logic [15:0]   year_bcd;
  logic [7:0]    month_bcd, day_bcd, hour_bcd, minute_bcd, second_bcd;
  logic [2:0]    weekday;

  int   errors = 0;
  int   checks = 0;
  cal_t exp_q[$];
  cal_t cur;

  unix_to_calendar_bcd #(.N(N), .MAX_YEAR(2099)) dut (
    .clk(clk), .rst_n(rst_n), .counter(counter),
    .busy(busy), .valid(valid), .range_err(range_err),
    .year_bcd(year_bcd), .month_bcd(month_bcd), .day_bcd(day_bcd),
    .hour_bcd(hour_bcd), .minute_bcd(minute_bcd), .second_bcd(second_bcd),
    .weekday(weekday)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Calendar reference: whole-day division, year/month walk, weekday straight from day count.
  function automatic cal_t model(input longint unsigned t);
    cal_t c;
    longint unsigned days, sod;
    int y, m;
    int ml[12];
    if (t >= 64'd4102444800) begin
      c.f  = {16'h2099, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59};
      c.wd = 3'd4;
      c.re = 1'b1;
      return c;
    end
    days = t / 86400;
    sod  = t % 86400;
    c.wd = 3'((days + 4) % 7);
    y = 1970;
    while (days >= ((y % 4 == 0) ? 366 : 365)) begin
      days -= ((y % 4 == 0) ? 366 : 365);
      y++;
    end
    ml = '{31, (y % 4 == 0) ? 29 : 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    m = 0;
    while (days >= longint'(ml[m])) begin
      days -= ml[m];
      m++;
    end
    c.f = {bcd2(y / 100), bcd2(y % 100), bcd2(m + 1), bcd2(int'(days) + 1),
           bcd2(int'(sod / 3600)), bcd2(int'((sod / 60) % 60)), bcd2(int'(sod % 60))};
    c.re = 1'b0;
    return c;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [55:0] dut_fields();
    return {year_bcd, month_bcd, day_bcd, hour_bcd, minute_bcd, second_bcd};
  endfunction

  // Outputs must always equal the most recently published expectation.
  always @(negedge clk) begin
    if (!rst_n) begin
      cur = model(64'd0);
      exp_q.delete();
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_valid", 64'(valid), 64'd0);
    end else if (valid) begin
      chk("valid_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) cur = exp_q.pop_front();
    end
    chk("cyc_fields", 64'(dut_fields()), 64'(cur.f));
    chk("cyc_weekday", 64'(weekday), 64'(cur.wd));
    chk("cyc_range_err", 64'(range_err), 64'(cur.re));
  end

  task automatic wait_valid(input string name);
    bit got;
    int lat;
    got = 1'b0;
    lat = 0;
    for (int k = 1; k <= LAT_MAX + 40 && !got; k++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        got = 1'b1;
        lat = k;
      end
    end
    chk({name, "_seen"}, 64'(got), 64'd1);
    if (got) chk({name, "_latency_ok"}, 64'(lat <= LAT_MAX), 64'd1);
  endtask

  task automatic run(input string name, input longint unsigned t,
                     input logic [55:0] lit, input logic [2:0] lwd, input logic lre);
    cal_t m;
    m = model(t);
    chk({name, "_model_fields"}, 64'(m.f), 64'(lit));
    chk({name, "_model_wd"}, 64'(m.wd), 64'(lwd));
    counter = t;
    exp_q.push_back(m);
    wait_valid(name);
    chk({name, "_fields"}, 64'(dut_fields()), 64'(lit));
    chk({name, "_weekday"}, 64'(weekday), 64'(lwd));
    chk({name, "_range_err"}, 64'(range_err), 64'(lre));
    repeat (2) @(posedge clk);
    #1;
    chk({name, "_busy_low"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
    $fatal(1);
  end

  initial begin
    rst_n   = 1'b0;
    counter = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_fields", 64'(dut_fields()), 64'({16'h1970, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00}));
    chk("reset_weekday", 64'(weekday), 64'd4);
    rst_n = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    chk("idle_busy", 64'(busy), 64'd0);

    run("eod_1970", 64'd86399,      {16'h1970, 8'h01, 8'h01, 8'h23, 8'h59, 8'h59}, 3'd4, 1'b0);
    run("leap_feb", 64'd951782400,  {16'h2000, 8'h02, 8'h29, 8'h00, 8'h00, 8'h00}, 3'd2, 1'b0);
    run("mar_2000", 64'd951868800,  {16'h2000, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00}, 3'd3, 1'b0);
    run("t1_7e9",   64'd1700000000, {16'h2023, 8'h11, 8'h14, 8'h22, 8'h13, 8'h20}, 3'd2, 1'b0);
    run("max_ok",   64'd4102444799, {16'h2099, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59}, 3'd4, 1'b0);
    run("clamp",    64'd4102444800, {16'h2099, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59}, 3'd4, 1'b1);

    // Change mid-conversion: both values must be published, in order.
    counter = 64'd1700000000;
    exp_q.push_back(model(64'd1700000000));
    exp_q.push_back(model(64'd0));
    repeat (5) @(posedge clk);
    #1;
    chk("midbusy_busy", 64'(busy), 64'd1);
    counter = 64'd0;
    wait_valid("midbusy_first");
    chk("midbusy_first_fields", 64'(dut_fields()), 64'({16'h2023, 8'h11, 8'h14, 8'h22, 8'h13, 8'h20}));
    wait_valid("midbusy_second");
    chk("midbusy_second_fields", 64'(dut_fields()), 64'({16'h1970, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00}));
    chk("midbusy_second_wd", 64'(weekday), 64'd4);

    // Reset during a conversion: immediate reset values, no valid afterwards.
    counter = 64'd951782400;
    repeat (20) @(posedge clk);
    #1;
    chk("rstmid_busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_fields", 64'(dut_fields()), 64'({16'h1970, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00}));
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_valid", 64'(valid), 64'd0);
    counter = 64'd0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (LAT_MAX + 40) @(posedge clk);
    #1;
    chk("rstmid_busy_after", 64'(busy), 64'd0);
    chk("rstmid_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
